// File: rtl/dmem_responder.sv
// dmem_responder: 4096 x 32 word-addressed data memory with byte-enabled writes and a line-fill tracker.
// Latency: a read accepted at edge t returns on DOUT at edge t+RD_LATENCY; a write lands at edge t.
// Backpressure: none. One request is accepted on every clock with CSN low, and reads stream back-to-back.
// Ports: CLK / RSTn (synchronous, active-low); CSN, WEN (both active-low), ADDR, BE, DI form the request;
//        DOUT / DOUT_VALID carry the read result; FILL_DONE marks the 4th word of an ascending line refill;
//        RD_CNT / WR_CNT are saturating counts of accepted reads and writes.
module dmem_responder #(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             CSN,
  input  logic [11:0]      ADDR,
  input  logic             WEN,
  input  logic [3:0]       BE,
  input  logic [31:0]      DI,
  output logic [31:0]      DOUT,
  output logic             DOUT_VALID,
  output logic             FILL_DONE,
  output logic [CNT_W-1:0] RD_CNT,
  output logic [CNT_W-1:0] WR_CNT
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // The array is zero at time 0 and is never cleared by reset.
  logic [31:0] mem [4096] = '{default: '0};

  // Read pipeline. Stage 0 captures the array word at the accepting edge;
  // DOUT is an extra output register that holds the last result.
  logic [31:0]           pipe_dat [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_fd;

  fill_state_t state;
  logic [9:0]  line;
  logic [1:0]  fill_next;

  logic rd_acc;
  logic wr_acc;
  logic fill_step;
  logic fill_last;

  assign rd_acc = RSTn & ~CSN & WEN;
  assign wr_acc = RSTn & ~CSN & ~WEN;

  // A read that extends the tracked line at the expected offset.
  assign fill_step = rd_acc && (state == FILL) &&
                     (ADDR[11:2] == line) && (ADDR[1:0] == fill_next);
  assign fill_last = fill_step && (fill_next == 2'b11);

  // Storage and read data path. No reset: memory persists across reset and the
  // data stages only matter when their valid bit is set.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (BE[i]) begin
          mem[ADDR][8*i +: 8] <= DI[8*i +: 8];
        end
      end
    end
    if (rd_acc) begin
      pipe_dat[0] <= mem[ADDR];
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_dat[i] <= pipe_dat[i-1];
    end
  end

  // Control: pipeline valids, output registers, counters and fill tracker.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      pipe_vld   <= '0;
      pipe_fd    <= '0;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      FILL_DONE  <= 1'b0;
      RD_CNT     <= '0;
      WR_CNT     <= '0;
      state      <= IDLE;
      line       <= '0;
      fill_next  <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      pipe_fd[0]  <= fill_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_fd[i]  <= pipe_fd[i-1];
      end

      DOUT_VALID <= pipe_vld[RD_LATENCY-1];
      FILL_DONE  <= pipe_fd[RD_LATENCY-1];
      if (pipe_vld[RD_LATENCY-1]) begin
        DOUT <= pipe_dat[RD_LATENCY-1];
      end

      if (rd_acc && (RD_CNT != '1)) begin
        RD_CNT <= RD_CNT + CNT_W'(1);
      end
      if (wr_acc && (WR_CNT != '1)) begin
        WR_CNT <= WR_CNT + CNT_W'(1);
      end

      // A read at offset 0 always (re)starts tracking on its own line, from
      // either state. Idle cycles leave the tracker untouched.
      if (rd_acc && (ADDR[1:0] == 2'b00)) begin
        state     <= FILL;
        line      <= ADDR[11:2];
        fill_next <= 2'b01;
      end else if (fill_step) begin
        fill_next <= fill_next + 2'b01;
        if (fill_last) begin
          state <= IDLE;
        end
      end else if (!CSN) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (latency 1 / 16-bit counters and latency 3 / 4-bit counters)
// share one stimulus stream and are compared every cycle against a behavioural model, with
// hand-computed literal expectations for the directed scenarios.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        csn;
  logic        wen;
  logic [11:0] addr;
  logic [3:0]  be;
  logic [31:0] di;

  logic [31:0] dout1, dout3;
  logic        vld1, vld3, fd1, fd3;
  logic [15:0] rd1, wr1;
  logic [3:0]  rd3, wr3;

  dmem_responder #(.RD_LATENCY(1), .CNT_W(16)) dut (
    .CLK(clk), .RSTn(rstn), .CSN(csn), .ADDR(addr), .WEN(wen), .BE(be), .DI(di),
    .DOUT(dout1), .DOUT_VALID(vld1), .FILL_DONE(fd1), .RD_CNT(rd1), .WR_CNT(wr1)
  );

  dmem_responder #(.RD_LATENCY(3), .CNT_W(4)) dut3 (
    .CLK(clk), .RSTn(rstn), .CSN(csn), .ADDR(addr), .WEN(wen), .BE(be), .DI(di),
    .DOUT(dout3), .DOUT_VALID(vld3), .FILL_DONE(fd3), .RD_CNT(rd3), .WR_CNT(wr3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          rd;
    logic [11:0] a;
  } req_t;

  logic [31:0] m_mem [4096];
  int          lat  [2] = '{1, 3};
  int          cmax [2] = '{65535, 15};
  int          rd_total = 0;
  int          wr_total = 0;
  logic [31:0] e_dout [2];
  bit          e_vld  [2];
  bit          e_fd   [2];
  bit          p_v [2][8];
  logic [31:0] p_d [2][8];
  bit          p_f [2][8];
  req_t        hist [$];
  int          cyc_n = 0;

  initial begin
    for (int i = 0; i < 4096; i++) m_mem[i] = '0;
    for (int d = 0; d < 2; d++) begin
      e_dout[d] = '0; e_vld[d] = 1'b0; e_fd[d] = 1'b0;
      for (int k = 0; k < 8; k++) p_v[d][k] = 1'b0;
    end
  end

  // A line fill completes when the last four accepted requests are reads of
  // one line at offsets 0,1,2,3 in that order.
  function automatic bit fill_complete();
    if (hist.size() != 4) return 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!hist[k].rd) return 1'b0;
      if (hist[k].a[11:2] != hist[0].a[11:2]) return 1'b0;
      if (hist[k].a[1:0] != 2'(k)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] sat(input int v, input int m);
    return (v > m) ? 32'(m) : 32'(v);
  endfunction

  always @(posedge clk) begin
    int   s, t;
    bit   done;
    req_t q;
    cyc_n++;
    s = cyc_n % 8;
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        e_dout[d] = '0; e_vld[d] = 1'b0; e_fd[d] = 1'b0;
        for (int k = 0; k < 8; k++) p_v[d][k] = 1'b0;
      end
      rd_total = 0;
      wr_total = 0;
      hist.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (p_v[d][s]) begin
          e_dout[d] = p_d[d][s]; e_vld[d] = 1'b1; e_fd[d] = p_f[d][s]; p_v[d][s] = 1'b0;
        end else begin
          e_vld[d] = 1'b0; e_fd[d] = 1'b0;
        end
      end
      if (!csn) begin
        q.rd = wen;
        q.a  = addr;
        hist.push_back(q);
        if (hist.size() > 4) void'(hist.pop_front());
        if (wen) begin
          done = fill_complete();
          rd_total++;
          for (int d = 0; d < 2; d++) begin
            t = (cyc_n + lat[d]) % 8;
            p_v[d][t] = 1'b1; p_d[d][t] = m_mem[addr]; p_f[d][t] = done;
          end
        end else begin
          wr_total++;
          for (int i = 0; i < 4; i++) if (be[i]) m_mem[addr][8*i +: 8] = di[8*i +: 8];
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout_l1",  dout1,      e_dout[0]);
      chk("vld_l1",   32'(vld1),  32'(e_vld[0]));
      chk("fill_l1",  32'(fd1),   32'(e_fd[0]));
      chk("rdcnt_l1", 32'(rd1),   sat(rd_total, cmax[0]));
      chk("wrcnt_l1", 32'(wr1),   sat(wr_total, cmax[0]));
      chk("dout_l3",  dout3,      e_dout[1]);
      chk("vld_l3",   32'(vld3),  32'(e_vld[1]));
      chk("fill_l3",  32'(fd3),   32'(e_fd[1]));
      chk("rdcnt_l3", 32'(rd3),   sat(rd_total, cmax[1]));
      chk("wrcnt_l3", 32'(wr3),   sat(wr_total, cmax[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input bit c, input bit w, input logic [11:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    csn = c; wen = w; addr = a; be = b; di = d;
    @(negedge clk);
  endtask

  task automatic idle();
    req(1'b1, 1'b1, 12'h000, 4'h0, 32'h0);
  endtask

  task automatic rd(input logic [11:0] a);
    req(1'b0, 1'b1, a, 4'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] b, input logic [31:0] d);
    req(1'b0, 1'b0, a, b, d);
  endtask

  initial begin
    logic [9:0]  ln;
    logic [11:0] ra;
    int          r;

    // Reset with a full write presented the whole time.
    rstn = 1'b0; csn = 1'b0; wen = 1'b0; addr = 12'h020; be = 4'hF; di = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_dout", dout1, 32'h0);
    chk("reset_vld", 32'(vld1), 32'h0);
    chk("reset_fill", 32'(fd1), 32'h0);
    chk("reset_rdcnt", 32'(rd1), 32'h0);
    chk("reset_wrcnt", 32'(wr1), 32'h0);
    rstn = 1'b1;
    idle();

    // Byte-enabled writes.
    wr(12'h010, 4'b1111, 32'hAABBCCDD);
    wr(12'h010, 4'b0101, 32'h11223344);
    rd(12'h010);
    idle();
    chk("byte_dout", dout1, 32'hAA22CC44);
    chk("byte_vld", 32'(vld1), 32'h1);
    chk("byte_wrcnt", 32'(wr1), 32'h2);
    chk("byte_rdcnt", 32'(rd1), 32'h1);
    rd(12'h020);
    idle();
    chk("reset_nowrite", dout1, 32'h0);
    chk("byte_dout_l3", dout3, 32'hAA22CC44);
    chk("byte_vld_l3", 32'(vld3), 32'h1);

    // Latency 3 timing.
    wr(12'h055, 4'hF, 32'h5A5A0001);
    rd(12'h055);
    idle();
    chk("lat3_early1", 32'(vld3), 32'h0);
    idle();
    chk("lat3_early2", 32'(vld3), 32'h0);
    idle();
    chk("lat3_vld", 32'(vld3), 32'h1);
    chk("lat3_dout", dout3, 32'h5A5A0001);

    // Full line fill.
    for (int k = 0; k < 4; k++) wr(12'h0A0 + 12'(k), 4'hF, 32'hF00D0000 + 32'(k));
    for (int k = 0; k < 4; k++) rd(12'h0A0 + 12'(k));
    chk("fill_w2_dout", dout1, 32'hF00D0002);
    chk("fill_w2_vld", 32'(vld1), 32'h1);
    chk("fill_w2_nodone", 32'(fd1), 32'h0);
    idle();
    chk("fill_w3_dout", dout1, 32'hF00D0003);
    chk("fill_w3_done", 32'(fd1), 32'h1);
    idle();
    idle();
    chk("fill_l3_done", 32'(fd3), 32'h1);
    chk("fill_l3_dout", dout3, 32'hF00D0003);

    // Broken by an intervening write.
    rd(12'h0A0); rd(12'h0A1); wr(12'h0A2, 4'h0, 32'h12345678); rd(12'h0A3);
    idle();
    chk("broken_nodone", 32'(fd1), 32'h0);
    chk("broken_dout", dout1, 32'hF00D0003);
    repeat (3) idle();

    // Idle gaps do not break a fill.
    for (int k = 0; k < 4; k++) begin
      rd(12'h0A0 + 12'(k));
      if (k < 3) begin idle(); idle(); end
    end
    idle();
    chk("gap_done", 32'(fd1), 32'h1);
    repeat (3) idle();

    // Reset while a read is in flight.
    wr(12'h033, 4'hF, 32'h00000077);
    rd(12'h033);
    rstn = 1'b0;
    idle();
    chk("midrst_dout", dout1, 32'h0);
    chk("midrst_vld", 32'(vld1), 32'h0);
    chk("midrst_dout_l3", dout3, 32'h0);
    chk("midrst_vld_l3", 32'(vld3), 32'h0);
    rstn = 1'b1;
    repeat (4) idle();
    chk("midrst_stale_l3", 32'(vld3), 32'h0);

    // Counter saturation.
    for (int k = 0; k < 20; k++) rd(12'($urandom_range(0, 4095)));
    repeat (4) idle();
    chk("sat_rdcnt_l3", 32'(rd3), 32'hF);
    chk("sat_rdcnt_l1", 32'(rd1), 32'd20);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      ra = 12'($urandom_range(0, 63));
      if (r < 2) begin
        rstn = 1'b0;
        req(1'b0, 1'($urandom_range(0, 1)), ra, 4'hF, $urandom);
        rstn = 1'b1;
      end else if (r < 8) begin
        ln = 10'($urandom_range(0, 15));
        for (int k = 0; k < 4; k++) begin
          rd({ln, 2'(k)});
          if ($urandom_range(0, 3) == 0) idle();
        end
      end else if (r < 30) begin
        idle();
      end else if (r < 65) begin
        rd(ra);
      end else begin
        wr(ra, 4'($urandom_range(0, 15)), $urandom);
      end
    end
    repeat (5) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
